// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    // All-zero word: the NOP encoding and the ROM fill for unprogrammed addresses.
    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // One prefetch queue slot: the word plus the address it came from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: ROM address/data, the decode handshake and the execute-stage
// redirect/halt controls. The master side is the fetch unit.
interface instr_fetch_if #(
    parameter int PC_W    = instr_fetch_pkg::PC_W,
    parameter int INSTR_W = instr_fetch_pkg::INSTR_W
);
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;

    modport master (
        output rom_addr, instr, instr_pc, instr_valid,
        input  rom_data, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid,
        output rom_data, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/instr_fetch_fetch_queue.sv
// fetch_queue: synchronous FIFO of DEPTH fetch entries. Flush empties it and
// overrides any push/pop in the same cycle. A push while full is accepted
// only together with a pop, so full-rate streaming needs no spare slot.
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t      mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; no reset needed because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, reads the combinational instruction ROM and
// feeds decoded-order words to decode through a small prefetch queue.
// Optional build macro SKIP_NOP_EN: when defined, all-zero (NOP) words are
// fetched past without being enqueued.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              PC_W     = instr_fetch_pkg::PC_W,
    parameter int              INSTR_W  = instr_fetch_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam logic [0:0] ST_RUN  = 1'(RUN);
    localparam logic [0:0] ST_HALT = 1'(HALT);

    logic [PC_W-1:0] fpc;
    logic [0:0]      state;
    logic            q_full;
    logic            q_empty;
    logic            pop;
    logic            fetch;
    logic            push;
    fetch_entry_t    entry;
    fetch_entry_t    head;

    // A fetch slot exists when running, not redirected, and the queue has
    // room now or frees a slot this cycle.
    assign pop   = ~q_empty & bus.instr_ready;
    assign fetch = (state == ST_RUN) & ~bus.halt & ~bus.redirect & (~q_full | pop);

`ifdef SKIP_NOP_EN
    assign push = fetch & (bus.rom_data != INSTR_W'(NOP_WORD));
`else
    assign push = fetch;
`endif

    // Pack the current fetch address with its ROM word.
    always_comb begin
        entry       = '0;
        entry.pc    = fpc;
        entry.instr = bus.rom_data;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (push),
        .pop   (pop),
        .wdata (entry),
        .head  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Fetch PC: redirect target wins, otherwise advance on every fetch slot
    // (including skipped NOPs) and wrap naturally at 2**PC_W.
    always_ff @(posedge clk) begin
        if (rst)
            fpc <= RESET_PC;
        else if (bus.redirect)
            fpc <= bus.redirect_pc;
        else if (fetch)
            fpc <= fpc + PC_W'(1);
    end

    // RUN/HALT follows the halt level; a redirect taken while halted keeps us halted.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else if (bus.redirect && state == ST_HALT)
            state <= ST_HALT;
        else
            state <= bus.halt ? ST_HALT : ST_RUN;
    end

    assign bus.rom_addr    = fpc;
    assign bus.instr_valid = ~q_empty;
    assign bus.instr       = q_empty ? '0 : head.instr;
    assign bus.instr_pc    = q_empty ? '0 : head.pc;
endmodule
